decrypt: RTL and testbench

DECRYPT -- requirements
Module: decrypt

---
 rtl/decrypt.sv | 109 ++++++++++
 tb/tb_decrypt.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/decrypt.sv
// Parallel substitution decrypter: each cipher byte is shifted back by the value of its
// repeating key letter within a scrambled alphabet, and the result is registered once.
module decrypt #(
  parameter int p_cipher_length = 1,
  parameter int p_secret_length = 6
) (
  input  logic                         i_w_clk,
  input  logic                         i_w_rst_n,
  input  logic [p_cipher_length*8-1:0] i_w_cipher,
  input  logic [p_secret_length*8-1:0] i_w_secret,
  output logic [p_cipher_length*8-1:0] o_r_text
);

  logic [p_cipher_length*8-1:0] text_d;
  logic [p_cipher_length*8-1:0] text_q;

  // Position of an uppercase letter in the alphabet; anything else counts as zero.
  function automatic logic [4:0] keyValue(input logic [7:0] ch);
    case (ch)
      "Q": keyValue = 5'd0;
      "W": keyValue = 5'd1;
      "R": keyValue = 5'd2;
      "T": keyValue = 5'd3;
      "Y": keyValue = 5'd4;
      "U": keyValue = 5'd5;
      "I": keyValue = 5'd6;
      "O": keyValue = 5'd7;
      "P": keyValue = 5'd8;
      "S": keyValue = 5'd9;
      "F": keyValue = 5'd10;
      "D": keyValue = 5'd11;
      "G": keyValue = 5'd12;
      "H": keyValue = 5'd13;
      "J": keyValue = 5'd14;
      "E": keyValue = 5'd15;
      "K": keyValue = 5'd16;
      "L": keyValue = 5'd17;
      "Z": keyValue = 5'd18;
      "X": keyValue = 5'd19;
      "C": keyValue = 5'd20;
      "V": keyValue = 5'd21;
      "B": keyValue = 5'd22;
      "N": keyValue = 5'd23;
      "M": keyValue = 5'd24;
      "A": keyValue = 5'd25;
      default: keyValue = 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] letterAt(input logic [7:0] pos);
    case (pos)
      8'd0:  letterAt = "Q";
      8'd1:  letterAt = "W";
      8'd2:  letterAt = "R";
      8'd3:  letterAt = "T";
      8'd4:  letterAt = "Y";
      8'd5:  letterAt = "U";
      8'd6:  letterAt = "I";
      8'd7:  letterAt = "O";
      8'd8:  letterAt = "P";
      8'd9:  letterAt = "S";
      8'd10: letterAt = "F";
      8'd11: letterAt = "D";
      8'd12: letterAt = "G";
      8'd13: letterAt = "H";
      8'd14: letterAt = "J";
      8'd15: letterAt = "E";
      8'd16: letterAt = "K";
      8'd17: letterAt = "L";
      8'd18: letterAt = "Z";
      8'd19: letterAt = "X";
      8'd20: letterAt = "C";
      8'd21: letterAt = "V";
      8'd22: letterAt = "B";
      8'd23: letterAt = "N";
      8'd24: letterAt = "M";
      8'd25: letterAt = "A";
      default: letterAt = 8'h3F;
    endcase
  endfunction

  // Cipher bytes above 51 never reach the subtractor result; the signed difference spans -25..51.
  always_comb begin
    text_d = '0;
    for (int k = 0; k < p_cipher_length; k++) begin
      logic [7:0]        cByte;
      logic [7:0]        kByte;
      logic signed [7:0] diff;
      cByte = i_w_cipher[(p_cipher_length-1-k)*8 +: 8];
      kByte = i_w_secret[(p_secret_length-1-(k % p_secret_length))*8 +: 8];
      diff  = $signed({1'b0, cByte[6:0]}) - $signed({3'b000, keyValue(kByte)});
      if (diff < 8'sd0)
        diff = diff + 8'sd26;
      else if (diff >= 8'sd26)
        diff = diff - 8'sd26;
      text_d[(p_cipher_length-1-k)*8 +: 8] = (cByte > 8'd51) ? 8'h3F : letterAt($unsigned(diff));
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n)
      text_q <= '0;
    else
      text_q <= text_d;
  end

  assign o_r_text = text_q;

endmodule

// File: tb/tb_decrypt.sv
// Randomized self-checking bench for decrypt at three cipher lengths against a
// string-based reference model of the alphabet-shift rules.
module tb_decrypt;

  logic        clk;
  logic        rstN;
  logic [7:0]  cipherA;
  logic [15:0] cipherB;
  logic [55:0] cipherC;
  logic [47:0] secret;
  logic [7:0]  textA;
  logic [15:0] textB;
  logic [55:0] textC;
  logic [55:0] expA;
  logic [55:0] expB;
  logic [55:0] expC;

  int compared   = 0;
  int mismatched = 0;

  decrypt #(.p_cipher_length(1), .p_secret_length(6)) dutA (
    .i_w_clk(clk), .i_w_rst_n(rstN), .i_w_cipher(cipherA), .i_w_secret(secret), .o_r_text(textA));
  decrypt #(.p_cipher_length(2), .p_secret_length(6)) dutB (
    .i_w_clk(clk), .i_w_rst_n(rstN), .i_w_cipher(cipherB), .i_w_secret(secret), .o_r_text(textB));
  decrypt #(.p_cipher_length(7), .p_secret_length(6)) dutC (
    .i_w_clk(clk), .i_w_rst_n(rstN), .i_w_cipher(cipherC), .i_w_secret(secret), .o_r_text(textC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decrypts n right-aligned bytes; the key string repeats every six characters.
  function automatic logic [55:0] refModel(input logic [55:0] cipher, input int n, input logic [47:0] key);
    string alphabet;
    logic [55:0] result;
    alphabet = "QWRTYUIOPSFDGHJEKLZXCVBNMA";
    result = '0;
    for (int k = 0; k < n; k++) begin
      int c;
      int kv;
      int d;
      logic [7:0] kb;
      c  = int'(cipher[(n-1-k)*8 +: 8]);
      kb = key[(5-(k % 6))*8 +: 8];
      kv = 0;
      if (kb >= "A" && kb <= "Z")
        for (int i = 0; i < 26; i++)
          if (alphabet[i] == kb) kv = i;
      if (c > 51) begin
        result[(n-1-k)*8 +: 8] = "?";
      end else begin
        d = c - kv;
        if (d < 0) d += 26;
        if (d >= 26) d -= 26;
        result[(n-1-k)*8 +: 8] = alphabet[d];
      end
    end
    return result;
  endfunction

  task automatic checkOutput(input string tag, input logic [55:0] observed, input logic [55:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [15:0] b, input logic [55:0] c,
                               input logic [47:0] s);
    cipherA = a;
    cipherB = b;
    cipherC = c;
    secret  = s;
    expA = refModel({48'd0, a}, 1, s);
    expB = refModel({40'd0, b}, 2, s);
    expC = refModel(c, 7, s);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_len1"}, {48'd0, textA}, expA);
    checkOutput({tag, "_len2"}, {40'd0, textB}, expB);
    checkOutput({tag, "_len7"}, textC, expC);
  endtask

  function automatic logic [7:0] randKeyByte();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return 8'("A" + $urandom_range(0, 25));
  endfunction

  function automatic logic [7:0] randCipherByte();
    if ($urandom_range(0, 7) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 53));
  endfunction

  initial begin
    logic [47:0] s;
    logic [55:0] c;
    logic [15:0] b;
    rstN = 1'b0;
    applyStimulus(8'd26, {8'd3, 8'd25}, {{6{8'd50}}, 8'd26}, "DANILA");
    #12;
    checkOutput("reset_len1", {48'd0, textA}, 56'd0);
    checkOutput("reset_len2", {40'd0, textB}, 56'd0);
    checkOutput("reset_len7", textC, 56'd0);

    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("danila_E", {48'd0, textA}, {48'd0, "E"});
    checkOutput("danila_ZQ", {40'd0, textB}, {40'd0, "ZQ"});
    checkOutput("danila_7", textC, "HAWZOAE");
    checkAll("danila_model");

    applyStimulus(8'd0, {8'd0, 8'd60}, {8'd0, 8'd51, 8'd52, 8'd255, 8'd25, 8'd26, 8'd1}, 48'd0);
    @(negedge clk);
    checkOutput("zerokey_Q", {48'd0, textA}, {48'd0, "Q"});
    checkOutput("zerokey_Qq", {40'd0, textB}, {40'd0, "Q?"});
    checkAll("zerokey_model");

    applyStimulus(8'd51, {8'd0, 8'd52}, {7{8'd0}}, "AAAAAA");
    @(negedge clk);
    checkAll("edge_51_52");

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 6; i++) s[i*8 +: 8] = randKeyByte();
      for (int i = 0; i < 7; i++) c[i*8 +: 8] = randCipherByte();
      b = {randCipherByte(), randCipherByte()};
      applyStimulus(randCipherByte(), b, c, s);
      @(negedge clk);
      checkAll("random");
    end

    applyStimulus(8'd26, {8'd3, 8'd25}, {{6{8'd50}}, 8'd26}, "DANILA");
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midreset_len1", {48'd0, textA}, 56'd0);
    checkOutput("midreset_len2", {40'd0, textB}, 56'd0);
    checkOutput("midreset_len7", textC, 56'd0);
    @(negedge clk);
    checkOutput("heldreset_len7", textC, 56'd0);
    rstN = 1'b1;
    @(negedge clk);
    checkAll("postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
